event_dispatcher: RTL and testbench



---
 rtl/event_dispatcher.sv | 142 ++++++++++++++
 tb/tb_event_dispatcher.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_dispatcher.sv
// event_dispatcher
//   Splits the ECD receive stream into two paths. Response messages (type 0)
//   are queued whole in a first-word-fall-through FIFO for the AXI4-Lite
//   response consumer. Event messages (type 1) are decoded into per-event
//   strobes, sticky flags and saturating counters. Input keeps flowing while
//   responses queue; it only stalls when the FIFO is full.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   ignore_rx          accepted beats are consumed and dropped
//   event_clear        per-bit clear of event_sticky (a same-cycle set wins)
//   count_clear        zeroes every event counter (beats a same-cycle increment)
//   event_strobe       one-cycle pulse per decoded event
//   event_sticky       latched event flags
//   event_count        packed saturating counters, event i at [i*CNT_WIDTH +: CNT_WIDTH]
//   bad_msg            one-cycle pulse on unknown type or out-of-range event id
//   AXIS_IN_*          message input stream
//   AXIS_OUT_*         response output stream
module event_dispatcher #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_EVENTS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             ignore_rx,
  input  logic [NUM_EVENTS-1:0]            event_clear,
  input  logic                             count_clear,
  output logic [NUM_EVENTS-1:0]            event_strobe,
  output logic [NUM_EVENTS-1:0]            event_sticky,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0]  event_count,
  output logic                             bad_msg,
  input  logic [DATA_WIDTH-1:0]            AXIS_IN_TDATA,
  input  logic                             AXIS_IN_TVALID,
  output logic                             AXIS_IN_TREADY,
  output logic [DATA_WIDTH-1:0]            AXIS_OUT_TDATA,
  output logic                             AXIS_OUT_TVALID,
  input  logic                             AXIS_OUT_TREADY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]          FIFO_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]          COUNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  // Nine bits so NUM_EVENTS up to 255 compares cleanly against an 8-bit id.
  localparam logic [8:0]           NUM_EV    = 9'(NUM_EVENTS);

  logic                  run;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           fifo_count;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [7:0]            msg_type;
  logic [7:0]            event_id;
  logic                  in_accept;
  logic                  live;
  logic                  id_in_range;
  logic                  push;
  logic                  pop;
  logic                  evt_ok;
  logic                  bad_in;
  logic [NUM_EVENTS-1:0] set_vec;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];

  assign msg_type    = AXIS_IN_TDATA[DATA_WIDTH-1 -: 8];
  assign event_id    = AXIS_IN_TDATA[7:0];

  // Ready depends on registers only, never on TVALID.
  assign AXIS_IN_TREADY = run & (fifo_count != FIFO_FULL);
  assign in_accept      = AXIS_IN_TVALID & AXIS_IN_TREADY;
  assign live           = in_accept & ~ignore_rx;
  assign id_in_range    = ({1'b0, event_id} < NUM_EV);

  assign push   = live & (msg_type == 8'd0);
  assign evt_ok = live & (msg_type == 8'd1) & id_in_range;
  assign bad_in = live & (msg_type != 8'd0) & ~((msg_type == 8'd1) & id_in_range);

  assign AXIS_OUT_TVALID = (fifo_count != '0);
  assign AXIS_OUT_TDATA  = mem[rd_ptr];
  assign pop             = AXIS_OUT_TVALID & AXIS_OUT_TREADY;

  always_comb begin
    set_vec = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      set_vec[i] = evt_ok & (event_id == 8'(i));
    end
  end

  // Run flag holds ready low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + COUNT_ONE;
        2'b01:   fifo_count <= fifo_count - COUNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= AXIS_IN_TDATA;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      event_strobe <= '0;
      event_sticky <= '0;
      bad_msg      <= 1'b0;
    end else begin
      event_strobe <= set_vec;
      event_sticky <= (event_sticky & ~event_clear) | set_vec;
      bad_msg      <= bad_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (!resetn || count_clear) begin
        cnt_q[i] <= '0;
      end else if (set_vec[i] && !(&cnt_q[i])) begin
        cnt_q[i] <= cnt_q[i] + CNT_ONE;
      end
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_count
    assign event_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule

// File: tb/tb_event_dispatcher.sv
module tb_event_dispatcher;

  localparam int DW = 32;
  localparam int NE = 8;
  localparam int FD = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ignore_rx;
  logic [NE-1:0] event_clear;
  logic          count_clear;
  logic [NE-1:0] event_strobe;
  logic [NE-1:0] event_sticky;
  logic [NE*CW-1:0] event_count;
  logic          bad_msg;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] d [5];

  event_dispatcher #(
    .DATA_WIDTH(DW), .NUM_EVENTS(NE), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ignore_rx       (ignore_rx),
    .event_clear     (event_clear),
    .count_clear     (count_clear),
    .event_strobe    (event_strobe),
    .event_sticky    (event_sticky),
    .event_count     (event_count),
    .bad_msg         (bad_msg),
    .AXIS_IN_TDATA   (in_tdata),
    .AXIS_IN_TVALID  (in_tvalid),
    .AXIS_IN_TREADY  (in_tready),
    .AXIS_OUT_TDATA  (out_tdata),
    .AXIS_OUT_TVALID (out_tvalid),
    .AXIS_OUT_TREADY (out_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] evt(input logic [7:0] id);
    return {8'h01, 16'h0000, id};
  endfunction

  function automatic logic [DW-1:0] resp(input int k);
    return {8'h00, 24'(32'hA5_0000 + k * 32'h111)};
  endfunction

  function automatic logic [CW-1:0] cnt(input int i);
    return event_count[i*CW +: CW];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 5; k++) d[k] = resp(k);
    resetn = 1'b0; ignore_rx = 1'b0; event_clear = '0; count_clear = 1'b0;
    in_tdata = '0; in_tvalid = 1'b0; out_tready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_in_tready",  in_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_strobe",     event_strobe, 0);
    check("rst_sticky",     event_sticky, 0);
    check("rst_bad",        bad_msg, 0);
    check("rst_count",      event_count, 0);
    resetn = 1'b1;
    check("rel_tready_c1", in_tready, 0);
    tick();
    check("rel_tready_c2", in_tready, 1);

    // Event decode, back to back
    out_tready = 1'b1;
    in_tvalid = 1'b1; in_tdata = evt(0);
    tick(); check("strobe_id0", event_strobe, 8'h01);
    in_tdata = evt(3);
    tick(); check("strobe_id3", event_strobe, 8'h08);
    in_tdata = evt(7);
    tick(); check("strobe_id7", event_strobe, 8'h80);
    check("sticky_89", event_sticky, 8'h89);
    in_tdata = evt(8);
    tick(); check("bad_id8", bad_msg, 1);
    check("bad_id8_strobe", event_strobe, 0);
    check("bad_id8_sticky", event_sticky, 8'h89);
    in_tvalid = 1'b0;
    tick(); check("bad_id8_once", bad_msg, 0);
    in_tvalid = 1'b1; in_tdata = {8'h02, 24'h000001};
    tick(); check("bad_type2", bad_msg, 1);
    in_tvalid = 1'b0;
    tick(); check("bad_type2_once", bad_msg, 0);
    check("count0", cnt(0), 1);
    check("count3", cnt(3), 1);
    check("count7", cnt(7), 1);
    check("count1", cnt(1), 0);
    check("no_resp_from_evt", out_tvalid, 0);

    // FIFO fill with output stalled
    out_tready = 1'b0;
    in_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_tdata = d[k];
      check($sformatf("fill_ready%0d", k), in_tready, 1);
      tick();
      check($sformatf("fill_vld%0d", k), out_tvalid, 1);
    end
    in_tdata = d[4];
    check("full_ready_low", in_tready, 0);
    check("full_head", out_tdata, d[0]);
    tick();
    check("d4_waits", in_tready, 0);
    out_tready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("drain_vld%0d", j), out_tvalid, 1);
      check($sformatf("drain_dat%0d", j), out_tdata, d[j]);
      tick();
      if (j == 1) in_tvalid = 1'b0;
    end
    check("drain_empty", out_tvalid, 0);

    // Push and pop together at count 2
    out_tready = 1'b0; in_tvalid = 1'b1;
    in_tdata = d[0]; tick();
    in_tdata = d[1]; tick();
    out_tready = 1'b1; in_tdata = d[2];
    tick();
    in_tvalid = 1'b0;
    check("pp_head", out_tdata, d[1]);
    check("pp_ready", in_tready, 1);
    tick();
    check("pp_second", out_tdata, d[2]);
    check("pp_second_vld", out_tvalid, 1);
    tick();
    check("pp_count2_empty", out_tvalid, 0);

    // Sticky clear vs set on bit 5
    event_clear = 8'hFF;
    tick(); check("clear_all", event_sticky, 0);
    event_clear = 8'h20; in_tvalid = 1'b1; in_tdata = evt(5);
    tick();
    event_clear = '0; in_tvalid = 1'b0;
    check("set_wins", event_sticky, 8'h20);
    event_clear = 8'h20;
    tick(); event_clear = '0;
    check("clear_bit5", event_sticky, 0);

    // count_clear coincident with an increment
    count_clear = 1'b1; in_tvalid = 1'b1; in_tdata = evt(0);
    tick();
    count_clear = 1'b0; in_tvalid = 1'b0;
    check("cc_strobe", event_strobe, 8'h01);
    check("cc_count", event_count, 0);
    tick();
    check("cc_count_hold", event_count, 0);

    // ignore_rx
    ignore_rx = 1'b1; in_tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       in_tdata = evt(8'(i % 8));
        1:       in_tdata = resp(i);
        default: in_tdata = {8'h07, 24'(i)};
      endcase
      check($sformatf("ign_ready%0d", i), in_tready, 1);
      tick();
      check($sformatf("ign_quiet%0d", i), {event_strobe, bad_msg, out_tvalid}, 0);
    end
    ignore_rx = 1'b0; in_tvalid = 1'b0;
    check("ign_counts", event_count, 0);
    check("ign_sticky", event_sticky, 8'h01);

    // Saturation
    in_tvalid = 1'b1; in_tdata = evt(2);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("sat_14", cnt(2), 14);
      if (k == 15) check("sat_15", cnt(2), 15);
    end
    in_tvalid = 1'b0;
    check("sat_20", cnt(2), 15);
    check("sat_others", cnt(1), 0);

    // Reset with responses queued
    out_tready = 1'b0; in_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_tdata = d[k]; tick();
    end
    in_tvalid = 1'b0;
    check("q3_vld", out_tvalid, 1);
    resetn = 1'b0;
    tick();
    check("mid_rst_out_vld", out_tvalid, 0);
    check("mid_rst_ready",   in_tready, 0);
    check("mid_rst_sticky",  event_sticky, 0);
    check("mid_rst_count",   event_count, 0);
    resetn = 1'b1;
    tick(); tick();
    check("post_rst_flushed", out_tvalid, 0);
    check("post_rst_ready",   in_tready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
